decode_ctrl_pipe: RTL and testbench

Registered successor to the combinational control decoder. It decodes RV32I/RV32E instructions into the datapath control bundle and holds the result in an ID/EX output register with valid/ready handshakes on both sides. It also detects load-use hazards, inserting one bubble per hazard, and accepts a branch-resolution flush. It sits between the fetch (IF/ID) register and the execute stage.

---
 rtl/decode_ctrl_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// RV32I/RV32E control decoder with a registered ID/EX output stage, valid/ready on both sides,
// one-bubble load-use hazard insertion and branch-resolution flush.
module decode_ctrl_pipe #(
  parameter int PC_WIDTH  = 32,
  parameter int RV32E     = 0,
  parameter int HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_jump,
  output logic                o_jalr,
  output logic                o_branch,
  output logic                o_mem_wr,
  output logic                o_mem_rd,
  output logic                o_arith,
  output logic                o_unsigned,
  output logic                o_sub,
  output logic                o_auipc,
  output logic                o_alu_src,
  output logic                o_rd_wen,
  output logic                o_illegal,
  output logic [2:0]          o_branch_type,
  output logic [1:0]          o_rd_dest_select,
  output logic [2:0]          o_opsel,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [4:0]          o_rd,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [31:0]         o_inst
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       mem_wr;
    logic       mem_rd;
    logic       arith;
    logic       is_unsigned;
    logic       sub;
    logic       auipc;
    logic       alu_src;
    logic       rd_wen;
    logic       illegal;
    logic [2:0] branch_type;
    logic [1:0] rd_dest_select;
    logic [2:0] opsel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  ctrl_t               dec;
  ctrl_t               ctrl_q;
  logic                use_rs1;
  logic                use_rs2;
  logic                known;
  logic                rv32e_bad;
  logic [2:0]          funct3;
  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         inst_q;
  logic                hazard;
  logic                accept;

  assign funct3 = i_inst[14:12];

  always_comb begin
    dec       = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    known     = 1'b1;
    rv32e_bad = 1'b0;
    dec.rs1   = i_inst[19:15];
    dec.rs2   = i_inst[24:20];
    dec.rd    = i_inst[11:7];
    case (i_inst[6:0])
      OP_R: begin
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        dec.rd_wen      = 1'b1;
        dec.opsel       = funct3;
        dec.sub         = (funct3 == 3'b000) ? i_inst[30] : (funct3[2:1] == 2'b01);
        dec.arith       = (funct3 == 3'b101) && i_inst[30];
        dec.is_unsigned = (funct3 == 3'b011);
      end
      OP_I: begin
        use_rs1         = 1'b1;
        dec.alu_src     = 1'b1;
        dec.rd_wen      = 1'b1;
        dec.opsel       = funct3;
        dec.sub         = (funct3[2:1] == 2'b01);
        dec.arith       = (funct3 == 3'b101) && i_inst[30];
        dec.is_unsigned = (funct3 == 3'b011);
      end
      OP_LOAD: begin
        use_rs1            = 1'b1;
        dec.mem_rd         = 1'b1;
        dec.rd_wen         = 1'b1;
        dec.alu_src        = 1'b1;
        dec.rd_dest_select = 2'b01;
      end
      OP_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.mem_wr  = 1'b1;
        dec.alu_src = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        dec.branch      = 1'b1;
        dec.branch_type = funct3;
        dec.sub         = 1'b1;
        dec.is_unsigned = (funct3[2:1] == 2'b11);
      end
      OP_JAL: begin
        dec.jump           = 1'b1;
        dec.rd_wen         = 1'b1;
        dec.rd_dest_select = 2'b10;
      end
      OP_JALR: begin
        use_rs1            = 1'b1;
        dec.jalr           = 1'b1;
        dec.jump           = 1'b1;
        dec.alu_src        = 1'b1;
        dec.rd_wen         = 1'b1;
        dec.rd_dest_select = 2'b10;
      end
      OP_LUI: begin
        dec.rd_wen         = 1'b1;
        dec.rd_dest_select = 2'b11;
      end
      OP_AUIPC: begin
        dec.auipc   = 1'b1;
        dec.alu_src = 1'b1;
        dec.rd_wen  = 1'b1;
      end
      default: known = 1'b0;
    endcase
    // Only register fields the format actually uses are checked; other formats reuse those bits as immediate.
    rv32e_bad = (RV32E != 0) && ((use_rs1 && i_inst[19]) || (use_rs2 && i_inst[24]) ||
                                 (dec.rd_wen && i_inst[11]));
    if (!known || rv32e_bad) begin
      dec.illegal = 1'b1;
      dec.rd_wen  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.branch  = 1'b0;
      dec.jump    = 1'b0;
      dec.jalr    = 1'b0;
    end
  end

  assign hazard  = (HAZARD_EN != 0) && valid_q && ctrl_q.mem_rd && (ctrl_q.rd != 5'd0) && i_valid &&
                   ((use_rs1 && (dec.rs1 == ctrl_q.rd)) || (use_rs2 && (dec.rs2 == ctrl_q.rd)));
  assign o_ready = (!valid_q || i_ready) && !hazard;
  assign accept  = i_valid && o_ready && !i_flush;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec;
      pc_q    <= i_pc;
      inst_q  <= i_inst;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid          = valid_q;
  assign o_jump           = ctrl_q.jump;
  assign o_jalr           = ctrl_q.jalr;
  assign o_branch         = ctrl_q.branch;
  assign o_mem_wr         = ctrl_q.mem_wr;
  assign o_mem_rd         = ctrl_q.mem_rd;
  assign o_arith          = ctrl_q.arith;
  assign o_unsigned       = ctrl_q.is_unsigned;
  assign o_sub            = ctrl_q.sub;
  assign o_auipc          = ctrl_q.auipc;
  assign o_alu_src        = ctrl_q.alu_src;
  assign o_rd_wen         = ctrl_q.rd_wen;
  assign o_illegal        = ctrl_q.illegal;
  assign o_branch_type    = ctrl_q.branch_type;
  assign o_rd_dest_select = ctrl_q.rd_dest_select;
  assign o_opsel          = ctrl_q.opsel;
  assign o_rs1            = ctrl_q.rs1;
  assign o_rs2            = ctrl_q.rs2;
  assign o_rd             = ctrl_q.rd;
  assign o_pc             = pc_q;
  assign o_inst           = inst_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Two decoder instances (RV32I with hazards, RV32E without) on shared stimulus,
// scoreboarded against an instruction-level reference model.
module tb_decode_ctrl_pipe;

  typedef struct packed {
    logic        jump, jalr, branch, mem_wr, mem_rd, arith, uns, sub, auipc, alu_src, rd_wen, illegal;
    logic [2:0]  btype;
    logic [1:0]  dest;
    logic [2:0]  opsel;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic [31:0] inst;
  } bundle_t;

  logic        clk, rst, valid, flush, irdy;
  logic [31:0] inst, pc;
  logic [1:0]  ov, ordy;
  bundle_t     got0, got1;
  int          total, bad;
  logic [31:0] pcn;

  bit          mv [2];
  bundle_t     mb [2];
  bundle_t     q0 [$];
  bundle_t     q1 [$];
  bit          he [2];
  bit          e32 [2];

  logic        j0, jr0, b0, mw0, mr0, a0, u0s, s0, au0, as0, w0, il0;
  logic [2:0]  bt0, op0;
  logic [1:0]  d0;
  logic [4:0]  r10, r20, rd0;
  logic [31:0] pc0, in0;
  logic        j1, jr1, b1, mw1, mr1, a1, u1s, s1, au1, as1, w1, il1;
  logic [2:0]  bt1, op1;
  logic [1:0]  d1;
  logic [4:0]  r11, r21, rd1;
  logic [31:0] pc1, in1;

  decode_ctrl_pipe #(.PC_WIDTH(32), .RV32E(0), .HAZARD_EN(1)) u_dut0 (
    .clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy[0]), .i_inst(inst), .i_pc(pc),
    .i_flush(flush), .o_valid(ov[0]), .i_ready(irdy), .o_jump(j0), .o_jalr(jr0), .o_branch(b0),
    .o_mem_wr(mw0), .o_mem_rd(mr0), .o_arith(a0), .o_unsigned(u0s), .o_sub(s0), .o_auipc(au0),
    .o_alu_src(as0), .o_rd_wen(w0), .o_illegal(il0), .o_branch_type(bt0), .o_rd_dest_select(d0),
    .o_opsel(op0), .o_rs1(r10), .o_rs2(r20), .o_rd(rd0), .o_pc(pc0), .o_inst(in0));

  decode_ctrl_pipe #(.PC_WIDTH(32), .RV32E(1), .HAZARD_EN(0)) u_dut1 (
    .clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy[1]), .i_inst(inst), .i_pc(pc),
    .i_flush(flush), .o_valid(ov[1]), .i_ready(irdy), .o_jump(j1), .o_jalr(jr1), .o_branch(b1),
    .o_mem_wr(mw1), .o_mem_rd(mr1), .o_arith(a1), .o_unsigned(u1s), .o_sub(s1), .o_auipc(au1),
    .o_alu_src(as1), .o_rd_wen(w1), .o_illegal(il1), .o_branch_type(bt1), .o_rd_dest_select(d1),
    .o_opsel(op1), .o_rs1(r11), .o_rs2(r21), .o_rd(rd1), .o_pc(pc1), .o_inst(in1));

  assign got0 = {j0, jr0, b0, mw0, mr0, a0, u0s, s0, au0, as0, w0, il0, bt0, d0, op0, r10, r20, rd0, pc0, in0};
  assign got1 = {j1, jr1, b1, mw1, mr1, a1, u1s, s1, au1, as1, w1, il1, bt1, d1, op1, r11, r21, rd1, pc1, in1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit uses1(input logic [31:0] w);
    return w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit uses2(input logic [31:0] w);
    return w[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Reference: what each instruction class means, straight from the ISA rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p, input bit e);
    bundle_t    b;
    logic [2:0] f;
    bit         ok;
    b = '0; f = w[14:12]; ok = 1'b1;
    b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.pc = p; b.inst = w;
    case (w[6:0])
      7'h33, 7'h13: begin
        b.rd_wen = 1; b.opsel = f; b.alu_src = (w[6:0] == 7'h13);
        if (f == 3'd2 || f == 3'd3) b.sub = 1;
        if (f == 3'd3) b.uns = 1;
        if (f == 3'd5) b.arith = w[30];
        if (f == 3'd0 && w[6:0] == 7'h33) b.sub = w[30];
      end
      7'h03: begin b.mem_rd = 1; b.rd_wen = 1; b.alu_src = 1; b.dest = 2'b01; end
      7'h23: begin b.mem_wr = 1; b.alu_src = 1; end
      7'h63: begin b.branch = 1; b.btype = f; b.sub = 1; b.uns = (f >= 3'd6); end
      7'h6f: begin b.jump = 1; b.rd_wen = 1; b.dest = 2'b10; end
      7'h67: begin b.jalr = 1; b.jump = 1; b.alu_src = 1; b.rd_wen = 1; b.dest = 2'b10; end
      7'h37: begin b.rd_wen = 1; b.dest = 2'b11; end
      7'h17: begin b.auipc = 1; b.alu_src = 1; b.rd_wen = 1; end
      default: ok = 1'b0;
    endcase
    if (e && ((uses1(w) && w[19]) || (uses2(w) && w[24]) || (b.rd_wen && w[11]))) ok = 1'b0;
    if (!ok) begin
      b.illegal = 1; b.rd_wen = 0; b.mem_wr = 0; b.mem_rd = 0; b.branch = 0; b.jump = 0; b.jalr = 0;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [4:0] r [3];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0b};
    for (int i = 0; i < 3; i++) begin
      r[i] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r[i] = r[i] + 5'd16;
    end
    return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r[2], r[1], 3'($urandom_range(0, 7)), r[0],
            ops[$urandom_range(0, 9)]};
  endfunction

  // One clock: drive at posedge+1, check ready/valid at +3 and advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic fl, input logic rdy);
    bit      hz, er;
    bundle_t exp;
    valid = v; inst = w; pc = pcn; flush = fl; irdy = rdy;
    pcn = pcn + 32'd4;
    #2;
    for (int k = 0; k < 2; k++) begin
      hz = he[k] && mv[k] && mb[k].mem_rd && (mb[k].rd != 0) && v &&
           ((uses1(w) && w[19:15] == mb[k].rd) || (uses2(w) && w[24:20] == mb[k].rd));
      er = (!mv[k] || rdy) && !hz;
      chk($sformatf("valid%0d", k), ov[k], mv[k]);
      chk($sformatf("ready%0d", k), ordy[k], er);
      if (fl) begin
        if (mv[k]) begin
          if (k == 0 && q0.size() > 0) void'(q0.pop_front());
          if (k == 1 && q1.size() > 0) void'(q1.pop_front());
        end
        mv[k] = 0;
      end else if (v && er) begin
        exp = ref_decode(w, pc, e32[k]);
        if (k == 0) q0.push_back(exp); else q1.push_back(exp);
        mb[k] = exp; mv[k] = 1;
      end else if (rdy) begin
        mv[k] = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; flush = 0; irdy = 0; inst = 0; pc = 0;
    @(posedge clk); #1;
    chk("rst_valid", ov, 2'b00);
    chk("rst_bundle0", got0, 0);
    chk("rst_bundle1", got1, 0);
    mv[0] = 0; mv[1] = 0; q0.delete(); q1.delete();
    rst = 0;
  endtask

  always @(negedge clk) begin : monitor
    bundle_t e;
    if (!rst) begin
      if (ov[0] && irdy && !flush) begin
        if (q0.size() == 0) begin
          total++; bad++; $display("FAIL out0_unexpected: got inst %0h expected none", got0.inst);
        end else begin
          e = q0.pop_front(); chk("out0", got0, e);
        end
      end
      if (ov[1] && irdy && !flush) begin
        if (q1.size() == 0) begin
          total++; bad++; $display("FAIL out1_unexpected: got inst %0h expected none", got1.inst);
        end else begin
          e = q1.pop_front(); chk("out1", got1, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; pcn = 32'h1000;
    he[0] = 1; he[1] = 0; e32[0] = 0; e32[1] = 1;
    do_reset();

    step(1, 32'h002081B3, 0, 1);
    chk("add_valid", ov[0], 1); chk("add_opsel", got0.opsel, 0); chk("add_sub", got0.sub, 0);
    chk("add_wen", got0.rd_wen, 1); chk("add_rd", got0.rd, 3); chk("add_alusrc", got0.alu_src, 0);
    step(1, 32'h402081B3, 0, 1);
    chk("sub_sub", got0.sub, 1);
    step(1, 32'h0050B213, 0, 1);
    chk("sltiu_opsel", got0.opsel, 3); chk("sltiu_sub", got0.sub, 1);
    chk("sltiu_uns", got0.uns, 1); chk("sltiu_alusrc", got0.alu_src, 1);

    step(1, 32'h0000A283, 0, 1);
    step(1, 32'h00528333, 0, 1);
    chk("bubble_valid0", ov[0], 0); chk("nobubble_valid1", ov[1], 1);
    step(1, 32'h00528333, 0, 1);
    chk("dep_valid", ov[0], 1); chk("dep_rd", got0.rd, 6);

    for (int i = 0; i < 3; i++) step(1, 32'h002081B3, 0, 0);
    step(1, 32'h002081B3, 0, 1);
    step(1, 32'h0050B213, 0, 1);
    step(1, 32'h402081B3, 1, 0);
    chk("flush_valid", ov, 2'b00);

    step(1, 32'h00000000, 0, 1);
    chk("zero_illegal", got0.illegal, 1); chk("zero_wen", got0.rd_wen, 0); chk("zero_memwr", got0.mem_wr, 0);
    step(1, 32'h00208833, 0, 1);
    chk("e_x16_illegal", got1.illegal, 1); chk("i_x16_legal", got0.illegal, 0);
    step(0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
